// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Holds the ALU control codes (also used by the ALU control decoder) and the
// sequencer state encoding.
package muldiv_seq_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Per-iteration datapath for unsigned shift-add multiply and restoring divide.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load           capture operand magnitudes and clear the accumulator
//   step           perform one iteration
//   div_mode       1 = restoring divide, 0 = shift-add multiply
//   a_mag, b_mag   unsigned operand magnitudes
//   prod_nxt_c     product accumulator value after the current iteration
//   quot_nxt_c     quotient value after the current iteration
//   rem_nxt_c      partial remainder value after the current iteration
module muldiv_iter_core
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] prod_nxt_c,
  output logic [WIDTH-1:0] quot_nxt_c,
  output logic [WIDTH-1:0] rem_nxt_c
);

  // acc: product (MUL) or partial remainder (DIV)
  // x:   multiplicand shifting left (MUL) or dividend/quotient shift (DIV)
  // y:   multiplier shifting right (MUL) or fixed divisor (DIV)
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_n, x_n, y_n;
  logic [WIDTH:0]   shifted, trial;

  // One iteration. The remainder only needs WIDTH stored bits because it is
  // always below the divisor; the shifted trial value carries the spare bit.
  always_comb begin
    acc_n   = acc;
    x_n     = x;
    y_n     = y;
    shifted = {acc, x[WIDTH-1]};
    trial   = shifted - {1'b0, y};
    if (div_mode) begin
      acc_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      x_n   = {x[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = {x[WIDTH-2:0], 1'b0};
      y_n   = {1'b0, y[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      x   <= '0;
      y   <= '0;
    end else if (load) begin
      acc <= '0;
      x   <= a_mag;
      y   <= b_mag;
    end else if (step) begin
      acc <= acc_n;
      x   <= x_n;
      y   <= y_n;
    end
  end

  assign prod_nxt_c = acc_n;
  assign quot_nxt_c = x_n;
  assign rem_nxt_c  = acc_n;

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MUL/DIV sequencer for the EX stage: accepts MUL/DIV codes,
// stalls the pipeline for WIDTH iterations and pulses a registered result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid        EX holds a valid instruction
//   alu_ctrl        ALU control code
//   src_a, src_b    two's complement operands
//   flush           abort any operation
//   stall           hold IF/ID/EX (combinational on accept)
//   result_valid    one-cycle pulse with result/remainder
//   result          MUL low product bits or DIV quotient
//   remainder       DIV remainder, 0 after MUL
//   busy            sequencer not idle
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             op_div, sign_a, sign_b;
  logic             accept, core_load, core_step, rv_n;
  logic [WIDTH-1:0] res_n, rem_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] prod_nxt, quot_nxt, rem_nxt;

  // Negation modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  assign a_mag = cneg(src_a, src_a[WIDTH-1]);
  assign b_mag = cneg(src_b, src_b[WIDTH-1]);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .step       (core_step),
    .div_mode   (op_div),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .prod_nxt_c (prod_nxt),
    .quot_nxt_c (quot_nxt),
    .rem_nxt_c  (rem_nxt)
  );

  // Next state, handshake and next result values
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    rv_n      = 1'b0;
    res_n     = result;
    rem_n     = remainder;
    stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_valid && !flush && (alu_ctrl == ALU_MUL || alu_ctrl == ALU_DIV)) begin
          accept    = 1'b1;
          core_load = 1'b1;
          cnt_n     = '0;
          if (alu_ctrl == ALU_DIV && src_b == '0) begin
            // Divide-by-zero finishes immediately with the captured dividend
            state_n = ST_DONE;
            rv_n    = 1'b1;
            res_n   = '1;
            rem_n   = src_a;
          end else begin
            state_n = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          core_step = 1'b1;
          cnt_n     = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state_n = ST_DONE;
            cnt_n   = '0;
            rv_n    = 1'b1;
            if (op_div) begin
              res_n = cneg(quot_nxt, sign_a ^ sign_b);
              rem_n = cneg(rem_nxt, sign_a);
            end else begin
              res_n = cneg(prod_nxt, sign_a ^ sign_b);
              rem_n = '0;
            end
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    stall = accept || (state == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Counter, captured operation attributes and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      op_div       <= 1'b0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      remainder    <= '0;
      busy         <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      result_valid <= rv_n;
      result       <= res_n;
      remainder    <= rem_n;
      busy         <= (state_n != ST_IDLE);
      if (accept) begin
        op_div <= (alu_ctrl == ALU_DIV);
        sign_a <= src_a[WIDTH-1];
        sign_b <= src_b[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed vector table, hand-written
// flush/reset/ignored-code sequences, and randomized ops against a signed
// arithmetic reference model.
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] src_a, src_b;
  logic         flush;
  logic         stall, result_valid, busy;
  logic [W-1:0] result, remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .alu_ctrl     (alu_ctrl),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .remainder    (remainder),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic [W-1:0] exp_rem;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed arithmetic on 64-bit integers, truncated to W bits
  task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == ALU_MUL) begin
      q = W'(sa * sb); r = '0; lat = W + 1;
    end else if (b == '0) begin
      q = '1; r = a; lat = 1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); lat = W + 1;
    end
  endtask

  // Issue one op in the current IDLE cycle with op_valid held through DONE.
  // Leaves the bench in the IDLE cycle after DONE with op_valid low.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] em,
                        input int lat);
    logic ok;
    ok = 1'b1;
    op_valid = 1'b1; alu_ctrl = op; src_a = a; src_b = b;
    #1;
    for (int k = 0; k < lat; k++) begin
      if (stall !== 1'b1 || result_valid !== 1'b0) ok = 1'b0;
      tick();
      if (k + 1 < lat) begin
        src_a = $urandom; src_b = $urandom;
      end
      #1;
    end
    chk({name, " stall_window"}, W'(ok), W'(1));
    chk({name, " done_rv_nostall"}, W'({result_valid, stall}), W'(2'b10));
    chk({name, " result"}, result, er);
    chk({name, " remainder"}, remainder, em);
    tick();
    op_valid = 1'b0;
    #1;
    chk({name, " idle_after_done"}, W'({busy, stall, result_valid}), W'(0));
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] q, r, held_res, held_rem;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int           lat;
    logic         ok;

    rst = 1'b1; op_valid = 1'b0; alu_ctrl = ALU_ADD; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_outputs", W'({stall, result_valid, busy}), W'(0));
    chk("reset_result", result, '0);
    chk("reset_remainder", remainder, '0);

    // Directed vectors; MUL 3x3 followed by DIV 9/3 runs back to back
    vecs.push_back('{ALU_MUL, 32'd7,          32'd6,          32'd42,         32'd0,          33});
    vecs.push_back('{ALU_DIV, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33});
    vecs.push_back('{ALU_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33});
    vecs.push_back('{ALU_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1});
    vecs.push_back('{ALU_MUL, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33});
    vecs.push_back('{ALU_DIV, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33});
    vecs.push_back('{ALU_DIV, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          33});
    vecs.push_back('{ALU_DIV, 32'hFFFF_FFF6,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF6,  1});
    vecs.push_back('{ALU_MUL, 32'd3,          32'd3,          32'd9,          32'd0,          33});
    vecs.push_back('{ALU_DIV, 32'd9,          32'd3,          32'd3,          32'd0,          33});
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_rem, vecs[i].lat);

    // Non-MUL/DIV codes must be ignored
    ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 4 || c == 5) continue;
      op_valid = 1'b1; alu_ctrl = 4'(c); src_a = $urandom; src_b = $urandom;
      #1;
      if (stall !== 1'b0) ok = 1'b0;
      tick();
      if (busy !== 1'b0 || result_valid !== 1'b0) ok = 1'b0;
    end
    op_valid = 1'b0;
    chk("ignored_codes", W'(ok), W'(1));
    chk("ignored_codes_hold_result", result, 32'd3);

    // flush together with a would-be accept
    op_valid = 1'b1; alu_ctrl = ALU_MUL; src_a = 32'd5; src_b = 32'd5; flush = 1'b1;
    #1;
    chk("flush_accept_stall", W'(stall), W'(0));
    tick();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    chk("flush_accept_busy", W'(busy), W'(0));

    // flush at T+10 of DIV 100/7
    held_res = result; held_rem = remainder;
    op_valid = 1'b1; alu_ctrl = ALU_DIV; src_a = 32'd100; src_b = 32'd7;
    #1;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("flush_busy_stall", W'({stall, busy}), W'(2'b11));
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle", W'({busy, stall, result_valid}), W'(0));
    chk("flush_result_held", result, held_res);
    chk("flush_rem_held", remainder, held_rem);
    ok = 1'b1;
    repeat (W + 4) begin
      tick();
      if (result_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("flush_no_late_result", W'(ok), W'(1));

    // reset at T+5 of a MUL
    op_valid = 1'b1; alu_ctrl = ALU_MUL; src_a = 32'd7; src_b = 32'd6;
    #1;
    tick();
    op_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_idle", W'({busy, stall, result_valid}), W'(0));
    chk("rst_mid_result", result, '0);
    ok = 1'b1;
    repeat (W + 4) begin
      tick();
      if (result_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_late_result", W'(ok), W'(1));

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(1) == 0) ? ALU_MUL : ALU_DIV;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(7))
        0: b = '0;
        1: b = W'($urandom_range(15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        4: begin a = W'($urandom_range(1000)); b = W'($urandom_range(40)) - W'(20); end
        default: ;
      endcase
      ref_op(op, a, b, q, r, lat);
      run_op($sformatf("rnd%0d", i), op, a, b, q, r, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
